// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - F/D freeze and D/E bubble control with MDU busy tracking.
// Optional STALL_CTRL_PERF_EN adds a free-running stall-cycle counter.
module stall_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic        d_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_start_mult,
  input  logic        e_start_div,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        halt_de,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       rs_hazard, rt_hazard, md_hazard, stall;

  // tuse == 3 marks an operand that is never read, so it cannot stall.
  assign rs_hazard = (d_rs != 5'd0) && (d_rs_tuse != 2'd3) &&
                     (((d_rs == e_wa) && (e_tnew > d_rs_tuse)) ||
                      ((d_rs == m_wa) && (m_tnew > d_rs_tuse)));
  assign rt_hazard = (d_rt != 5'd0) && (d_rt_tuse != 2'd3) &&
                     (((d_rt == e_wa) && (e_tnew > d_rt_tuse)) ||
                      ((d_rt == m_wa) && (m_tnew > d_rt_tuse)));

  assign md_busy   = (state != IDLE);
  assign md_hazard = d_md && (md_busy || e_start_mult || e_start_div);
  assign stall     = rs_hazard || rt_hazard || md_hazard;

  assign stall_pc = stall && !req;
  assign stall_fd = stall && !req;
  assign halt_de  = stall && !req;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    md_done    = 1'b0;
    case (state)
      IDLE: begin
        // A flush drops a start that has not yet been committed to the MDU.
        if (!req) begin
          if (e_start_mult) begin
            state_next = MULT;
            cnt_next   = MULT_LOAD;
          end else if (e_start_div) begin
            state_next = DIV;
            cnt_next   = DIV_LOAD;
          end
        end
      end
      MULT, DIV: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          md_done    = !reset;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else if (stall_pc) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
